// File: rtl/rom_reader_if.sv
// rom_reader_if: request, ROM and consumer signals of the burst ROM reader.
//   start/base_addr/length    burst request from the requester
//   rom_address/rom_en        read port towards a synchronous ROM
//   rom_data                  ROM output, valid one clock after the address
//   data_out/data_valid/data_ready  word handoff to the consumer
//   busy/done                 burst status
// modport slave is the reader itself; modport master is its environment.
interface rom_reader_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic [ADDR_W-1:0] rom_address;
   logic              rom_en;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready;
   logic              busy;
   logic              done;

   modport slave (
      input  start, base_addr, length, rom_data, data_ready,
      output rom_address, rom_en, data_out, data_valid, busy, done
   );

   modport master (
      output start, base_addr, length, rom_data, data_ready,
      input  rom_address, rom_en, data_out, data_valid, busy, done
   );
endinterface

// File: rtl/rom_reader.sv
// rom_reader: reads a burst of consecutive words from a synchronous ROM and
// hands them one at a time to a valid/ready consumer.
//   clock    rising-edge system clock
//   reset_n  asynchronous active-low reset
//   bus      rom_reader_if.slave (request, ROM read port, consumer port, status)
// One word takes FETCH -> CAPTURE -> OUTPUT, so three cycles per word when the
// consumer never stalls. Addresses wrap modulo 2^ADDR_W.
module rom_reader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input logic        clock,
   input logic        reset_n,
   rom_reader_if.slave bus
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FETCH   = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] OUTPUT  = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W-1:0] rom_address_q, rom_address_d;
   logic              rom_en_q, rom_en_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              data_valid_q, data_valid_d;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      count_d       = count_q;
      rom_address_d = rom_address_q;
      rom_en_d      = 1'b0;
      data_out_d    = data_out_q;
      data_valid_d  = data_valid_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.length != '0) begin
                  addr_d        = bus.base_addr;
                  count_d       = bus.length;
                  // Address and enable are registered, so they are loaded on
                  // the edge that enters FETCH.
                  rom_address_d = bus.base_addr;
                  rom_en_d      = 1'b1;
                  state_d       = FETCH;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FETCH: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            data_out_d   = bus.rom_data;
            data_valid_d = 1'b1;
            state_d      = OUTPUT;
         end
         OUTPUT: begin
            // data_valid is always high here, so data_ready alone is the handshake.
            if (bus.data_ready) begin
               data_valid_d = 1'b0;
               count_d      = count_q - 1'b1;
               addr_d       = addr_q + 1'b1;
               if (count_q == (ADDR_W+1)'(1)) begin
                  state_d = DONE;
               end else begin
                  rom_address_d = addr_q + 1'b1;
                  rom_en_d      = 1'b1;
                  state_d       = FETCH;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         count_q       <= '0;
         rom_address_q <= '0;
         rom_en_q      <= 1'b0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         count_q       <= count_d;
         rom_address_q <= rom_address_d;
         rom_en_q      <= rom_en_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
      end
   end

   assign bus.rom_address = rom_address_q;
   assign bus.rom_en      = rom_en_q;
   assign bus.data_out    = data_out_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = (state_q == DONE);

endmodule
